gamepad_poll_controller: RTL
============================

GAMEPAD_POLL_CONTROLLER -- requirements
Module: gamepad_poll_controller

Interface
REQ-001 Parameter POLL_INTERVAL, default 833_333, clk cycles from the start of one poll to the start of the next (60 Hz at 50 MHz).
REQ-002 Parameter POLL_TIMEOUT, default 131_072, maximum clk cycles POLL may last before it is aborted.
REQ-003 Parameter FIFO_DEPTH, default 4, number of entries in the event FIFO (power of two, 2..16).
REQ-004 clk  input  1  single system clock; all logic is clocked on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 spi_reset  output  1  active-high hold to the DualShock SPI master; 1 parks the master, 0 lets it run a transaction.
REQ-007 spi_data_valid  input  1  frame-complete flag from the SPI master.
REQ-008 spi_rx  input  16  button bytes from the SPI master, active-low, LSB = button 0.
REQ-009 buttons  output  16  debounced button state, active-high (1 = pressed).
REQ-010 evt_valid  output  1  event FIFO not empty.
REQ-011 evt_data  output  5  head event {pressed, index[3:0]}.
REQ-012 evt_ready  input  1  pop the head event when evt_valid is 1.
REQ-013 overflow  output  1  sticky flag, set when an event was dropped.
REQ-014 ovf_clear  input  1  clears overflow.
REQ-015 timeout_cnt  output  8  saturating count of aborted polls.

Function
REQ-016 FSM states: IDLE, POLL, CAPTURE, EMIT.
REQ-017 IDLE: spi_reset=1; the interval counter runs; at POLL_INTERVAL-1 the FSM goes to POLL and the interval counter restarts, so polls start every POLL_INTERVAL cycles independent of poll length.
REQ-018 POLL: spi_reset=0; a rising edge of spi_data_valid (1 now, 0 the previous cycle; edge register cleared in IDLE) moves the FSM to CAPTURE.
REQ-019 POLL: when the timeout counter reaches POLL_TIMEOUT-1, timeout_cnt increments (saturating at 255) and the FSM returns to IDLE; buttons are unchanged.
REQ-020 CAPTURE (1 cycle): frame = ~spi_rx; if frame equals the previous raw frame, candidate = frame, otherwise candidate = buttons (no change); the previous raw frame is updated; changed = candidate ^ buttons; buttons <= candidate; then EMIT.
REQ-021 EMIT: each cycle, take the lowest set bit i of changed, push {candidate[i], i} into the FIFO, and clear bit i; when changed is 0, return to IDLE; EMIT lasts popcount(changed) cycles (0 cycles to IDLE if changed is 0).
REQ-022 A push to a full FIFO is dropped and sets overflow; a simultaneous pop in that cycle frees a slot, so the push succeeds.
REQ-023 Pop and push in the same cycle on a non-empty FIFO: count is unchanged and order is preserved.
REQ-024 evt_ready while evt_valid=0 is ignored.
REQ-025 ovf_clear has priority over a same-cycle overflow set (the flag reads 0 next cycle).
REQ-026 If the interval expires while not in IDLE, the next poll starts at the first IDLE cycle.
REQ-027 Pointers wrap modulo FIFO_DEPTH; the count is $clog2(FIFO_DEPTH)+1 bits wide.

Reset
REQ-028 Asynchronous assertion, with all state forced: FSM=IDLE, spi_reset=1, buttons=0, previous frame=0, FIFO empty (evt_valid=0, evt_data=0), overflow=0, timeout_cnt=0, all counters=0.
REQ-029 reset_n asserted mid-POLL or mid-EMIT aborts the operation; partial events are discarded.

Structure
REQ-030 Package gamepad_pkg holds: the state enum, the event struct {pressed, index}, the BUTTON_COUNT=16 constant, and the default timing constants.
REQ-031 The event FIFO is one sub-module, gamepad_event_fifo (synchronous, parameterised depth, full/empty flags).

Verification
REQ-032 Test 1: two frames spi_rx=16'hFFFE -> buttons=16'h0001 after the second CAPTURE; exactly one event {1,0}.
REQ-033 Test 2: frames 16'hFFFE then 16'hFFFF -> no change; a third 16'hFFFF -> buttons=0 and event {0,0}.
REQ-034 Test 3: stable frame 16'h0000 from reset, no pops -> 4 events {1,0}..{1,3} stored, overflow=1; ovf_clear -> overflow=0.
REQ-035 Test 4: spi_data_valid held 0 -> after POLL_TIMEOUT cycles, timeout_cnt=1 and the FSM is in IDLE with spi_reset=1.
REQ-036 Test 5: reset_n pulsed during EMIT -> all outputs return to their reset values immediately; the next poll runs normally.
REQ-037 Test 6: with POLL_INTERVAL=100, measure spi_reset falling edges -> exactly 100 cycles apart across 5 polls.

Source files
------------

// File: rtl/gamepad_pkg.sv
// Shared types and constants for the gamepad poll controller: FSM states,
// the button event record and the default timing values.
package gamepad_pkg;

    localparam int BUTTON_COUNT = 16;
    localparam int INDEX_W      = $clog2(BUTTON_COUNT);

    localparam int DEFAULT_POLL_INTERVAL = 833_333;
    localparam int DEFAULT_POLL_TIMEOUT  = 131_072;
    localparam int DEFAULT_FIFO_DEPTH    = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_POLL,
        ST_CAPTURE,
        ST_EMIT
    } state_t;

    typedef struct packed {
        logic               pressed;
        logic [INDEX_W-1:0] index;
    } event_t;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [INDEX_W-1:0] lowest_set(input logic [BUTTON_COUNT-1:0] v);
        logic [INDEX_W-1:0] idx;
        idx = '0;
        for (int i = BUTTON_COUNT - 1; i >= 0; i--) begin
            if (v[i]) idx = INDEX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/gamepad_poll_controller_if.sv
// Button event stream: valid/ready handshake carrying one {pressed, index} event.
interface gamepad_poll_controller_if;
    import gamepad_pkg::*;

    logic   evt_valid;
    event_t evt_data;
    logic   evt_ready;

    modport master (output evt_valid, output evt_data, input evt_ready);
    modport slave  (input evt_valid, input evt_data, output evt_ready);

endinterface

// File: rtl/gamepad_event_fifo.sv
// Small synchronous event FIFO with full/empty flags; a pop in the same cycle
// lets a push into a full FIFO succeed.
module gamepad_event_fifo
    import gamepad_pkg::*;
#(
    parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic   clk,
    input  logic   reset_n,
    input  logic   push,
    input  event_t push_data,
    input  logic   pop,
    output event_t head,
    output logic   full,
    output logic   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    event_t           mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CNT_W'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign head    = empty ? '0 : mem_reg[rd_ptr_reg];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
        end else if (push_ok) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/gamepad_poll_controller.sv
// Periodically polls a DualShock SPI master, debounces the button frame over two
// identical reads and queues one event per changed button.
module gamepad_poll_controller
    import gamepad_pkg::*;
#(
    parameter int POLL_INTERVAL = DEFAULT_POLL_INTERVAL,
    parameter int POLL_TIMEOUT  = DEFAULT_POLL_TIMEOUT,
    parameter int FIFO_DEPTH    = DEFAULT_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          reset_n,
    output logic                          spi_reset,
    input  logic                          spi_data_valid,
    input  logic [BUTTON_COUNT-1:0]       spi_rx,
    output logic [BUTTON_COUNT-1:0]       buttons,
    gamepad_poll_controller_if.master     evt,
    output logic                          overflow,
    input  logic                          ovf_clear,
    output logic [7:0]                    timeout_cnt
);

    localparam int INT_W  = $clog2(POLL_INTERVAL);
    localparam int TOUT_W = $clog2(POLL_TIMEOUT);

    state_t                  state_reg, state_next;
    logic [INT_W-1:0]        interval_cnt_reg;
    logic                    poll_due_reg;
    logic [TOUT_W-1:0]       tout_cnt_reg;
    logic                    dv_prev_reg;
    logic [BUTTON_COUNT-1:0] prev_frame_reg;
    logic [BUTTON_COUNT-1:0] buttons_reg;
    logic [BUTTON_COUNT-1:0] candidate_reg;
    logic [BUTTON_COUNT-1:0] changed_reg, changed_next;
    logic                    overflow_reg;
    logic [7:0]              timeout_cnt_reg;

    logic                    interval_wrap;
    logic                    poll_start;
    logic                    dv_rise;
    logic                    tout_last;
    logic                    timeout_hit;
    logic [BUTTON_COUNT-1:0] frame;
    logic [BUTTON_COUNT-1:0] candidate;
    logic [INDEX_W-1:0]      emit_idx;
    logic                    push;
    event_t                  push_data;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    dropped;

    assign interval_wrap = (interval_cnt_reg == INT_W'(POLL_INTERVAL - 1));
    // A wrap seen outside IDLE is remembered so the poll starts at the next IDLE cycle.
    assign poll_start    = (state_reg == ST_IDLE) && (interval_wrap || poll_due_reg);
    assign dv_rise       = spi_data_valid && !dv_prev_reg;
    assign tout_last     = (tout_cnt_reg == TOUT_W'(POLL_TIMEOUT - 1));
    assign frame         = ~spi_rx;
    assign candidate     = (frame == prev_frame_reg) ? frame : buttons_reg;
    assign emit_idx      = lowest_set(changed_reg);

    always_comb begin
        state_next   = state_reg;
        changed_next = changed_reg;
        push         = 1'b0;
        push_data    = '0;
        timeout_hit  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (poll_start) state_next = ST_POLL;
            end
            ST_POLL: begin
                if (dv_rise) begin
                    state_next = ST_CAPTURE;
                end else if (tout_last) begin
                    timeout_hit = 1'b1;
                    state_next  = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                changed_next = candidate ^ buttons_reg;
                state_next   = (changed_next == '0) ? ST_IDLE : ST_EMIT;
            end
            ST_EMIT: begin
                push              = 1'b1;
                push_data.pressed = candidate_reg[emit_idx];
                push_data.index   = emit_idx;
                changed_next      = changed_reg & (changed_reg - BUTTON_COUNT'(1));
                state_next        = (changed_next == '0) ? ST_IDLE : ST_EMIT;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg        <= ST_IDLE;
            interval_cnt_reg <= '0;
            poll_due_reg     <= 1'b0;
            tout_cnt_reg     <= '0;
            dv_prev_reg      <= 1'b0;
            prev_frame_reg   <= '0;
            buttons_reg      <= '0;
            candidate_reg    <= '0;
            changed_reg      <= '0;
            overflow_reg     <= 1'b0;
            timeout_cnt_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            changed_reg <= changed_next;

            interval_cnt_reg <= interval_wrap ? '0 : interval_cnt_reg + 1'b1;
            if (poll_start)         poll_due_reg <= 1'b0;
            else if (interval_wrap) poll_due_reg <= 1'b1;

            tout_cnt_reg <= (state_reg == ST_POLL) ? tout_cnt_reg + 1'b1 : '0;
            dv_prev_reg  <= (state_reg == ST_IDLE) ? 1'b0 : spi_data_valid;

            if (state_reg == ST_CAPTURE) begin
                prev_frame_reg <= frame;
                buttons_reg    <= candidate;
                candidate_reg  <= candidate;
            end

            if (ovf_clear)    overflow_reg <= 1'b0;
            else if (dropped) overflow_reg <= 1'b1;

            if (timeout_hit && timeout_cnt_reg != 8'hFF)
                timeout_cnt_reg <= timeout_cnt_reg + 8'd1;
        end
    end

    gamepad_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (push_data),
        .pop       (evt.evt_ready),
        .head      (evt.evt_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign dropped       = push && fifo_full && !(evt.evt_ready && !fifo_empty);
    assign evt.evt_valid = !fifo_empty;
    assign spi_reset     = (state_reg != ST_POLL);
    assign buttons       = buttons_reg;
    assign overflow      = overflow_reg;
    assign timeout_cnt   = timeout_cnt_reg;

endmodule
